// File: rtl/pipe_shift_reg_param_if.sv
// Handshake/bus bundle for pipe_shift_reg_param: stage-0 input, per-stage stall/flush, stage outputs.
// The master side drives the pipeline controls; the slave side is the shift register itself.
interface pipe_shift_reg_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                   load;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [DEPTH-1:0]       stage_valid;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output load, in_valid, in_data, stall, flush,
    input  in_ready, stage_data, stage_valid, occupancy
  );

  modport slave (
    input  load, in_valid, in_data, stall, flush,
    output in_ready, stage_data, stage_valid, occupancy
  );
endinterface

// File: rtl/pipe_shift_reg_param.sv
// DEPTH-stage WIDTH-bit pipeline register with per-stage stall (bubble insertion), flush and occupancy.
// Optional macro PIPE_SHIFT_FLUSH_ZERO_EN: flushed or bubbled stages also have their data cleared to 0.
module pipe_shift_reg_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  pipe_shift_reg_param_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef PIPE_SHIFT_FLUSH_ZERO_EN
  localparam bit SQUASH_ZERO = 1'b1;
`else
  localparam bit SQUASH_ZERO = 1'b0;
`endif

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0][WIDTH-1:0] prev_data_s;
  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0]            prev_valid_s;
  logic [DEPTH-1:0]            hold_s;
  logic [DEPTH-1:0]            hold_up_s;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // A stall anywhere freezes that stage and everything upstream of it.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    hold_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc       = acc | bus.stall[i];
      hold_s[i] = acc;
    end
  end

  // Stage i's upstream neighbour; stage 0's neighbour is the input port, which never holds.
  assign hold_up_s    = {hold_s[DEPTH-2:0], 1'b0};
  assign prev_valid_s = {valid_q[DEPTH-2:0], bus.in_valid};
  assign prev_data_s  = {data_q[DEPTH-2:0], bus.in_data};

  // Per-stage next state: flush, then freeze, then bubble, then shift.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = SQUASH_ZERO ? {WIDTH{1'b0}} : data_q[i];
      end else if (!bus.load || hold_s[i]) begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
      end else if (hold_up_s[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = SQUASH_ZERO ? {WIDTH{1'b0}} : data_q[i];
      end else begin
        valid_d[i] = prev_valid_s[i];
        data_d[i]  = prev_data_s[i];
      end
    end
    occ_d = popcount(valid_d);
  end

  // Stage registers and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready    = bus.load & ~hold_s[0];
  assign bus.stage_data  = data_q;
  assign bus.stage_valid = valid_q;
  assign bus.occupancy   = occ_q;
endmodule
